stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control stage directly upstream of the lab's digit up-counters (count-enable / load-initial / wrap / carry chain).
- Debounces and one-pulses the start/stop, reset and lap push-buttons.
- Runs the INIT/PAUSE/RUN state machine.
- Divides the board clock into a single-cycle count-enable pulse. It produces the `increase` and `rst_state` signals that the lowest counter digit consumes, plus a lap-freeze flag for the display path.

Parameters:
- TICK_DIV, 10_000_000: clk cycles per count tick (0.1 s at 100 MHz); must be >= 2.
- DEB_DIV, 100_000: clk cycles between debounce samples; must be >= 1.
- DEB_LEN, 4: consecutive equal samples required to change the debounced level; must be >= 2.

Ports:
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- btn_start  in  1  raw start/stop button, active high, asynchronous to clk
- btn_reset  in  1  raw reset button, active high, asynchronous
- btn_lap  in  1  raw lap button, active high, asynchronous
- increase  out  1  one-cycle count-enable pulse to the least-significant counter digit
- rst_state  out  1  high while in INIT; counters load their initial value
- lap_hold  out  1  high = display shows frozen lap value
- state  out  2  current FSM state: 00 INIT, 01 PAUSE, 10 RUN; 11 unused

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset:
  - state = INIT, rst_state = 1, increase = 0, lap_hold = 0.
  - All counters, synchronisers, shift registers and debounced levels are cleared to 0.
- Input conditioning, per button:
  - Two-flop synchroniser.
  - Shared sample divider counts 0..DEB_DIV-1; a strobe fires on the cycle it equals DEB_DIV-1, then it wraps to 0.
  - On each strobe, the synchronised bit shifts into a DEB_LEN-bit shift register.
  - Debounced level goes to 1 when the register is all ones and to 0 when all zeros; otherwise it holds.
  - Press pulse = registered (level & ~level_prev). It is exactly one cycle per press, regardless of hold time.
  - Bounces shorter than DEB_LEN samples never produce a pulse.
- FSM transitions, evaluated each cycle on press pulses (p_start, p_reset, p_lap):
  - INIT: p_start -> RUN; else stay. p_reset is ignored (already reset).
  - PAUSE: p_reset -> INIT; else p_start -> RUN; else stay.
  - RUN: p_reset -> INIT; else p_start -> PAUSE; else stay.
  - Simultaneous p_reset and p_start: reset wins.
  - Illegal encoding 11 -> INIT on the next clock.
- Outputs:
  - rst_state = (state == INIT), registered with the state.
  - Tick counter, width clog2(TICK_DIV):
    - Cleared to 0 in INIT.
    - Holds its value in PAUSE, so a resume keeps its phase.
    - In RUN, increments and wraps from TICK_DIV-1 to 0.
  - increase = 1 for exactly the cycle in which state == RUN and tick counter == TICK_DIV-1. The first tick after entering RUN from INIT arrives TICK_DIV cycles after the state change.
  - Transition RUN -> PAUSE on the same cycle as a terminal count: increase is still asserted that cycle (decision made on current state); the counter wraps to 0 and holds.
  - lap_hold toggles on p_lap only in RUN. p_lap is ignored in INIT and PAUSE. lap_hold is forced to 0 on entry to INIT. It never affects increase; counting continues underneath a frozen display.
- No combinational path from buttons to outputs. All outputs are registered.

Test Plan:
Bench parameters TICK_DIV=4, DEB_DIV=2, DEB_LEN=3.
1. Reset, then hold btn_start high for 20 cycles -> exactly one p_start; state 00->10 within 14 cycles of the press. rst_state falls with the state change. increase pulses every 4th cycle, first pulse 4 cycles after entry to RUN.
2. Glitch btn_start high for 3 cycles (< DEB_LEN samples), repeated 5 times with 3-cycle gaps -> no state change, increase stays 0.
3. In RUN, press start at tick count 2 -> PAUSE, increase silent for 30 cycles. Press start again -> RUN, first increase 1 cycle after re-entry (counter resumed at 3).
4. In RUN, press btn_start and btn_reset so their pulses coincide -> state = INIT, rst_state = 1, tick counter 0, no increase.
5. In RUN, press lap -> lap_hold = 1 while increase keeps pulsing every 4 cycles. Press lap again -> lap_hold = 0. Set lap_hold, then press reset -> lap_hold = 0 and state = INIT.
6. Assert rst_n low mid-RUN for 1 cycle, asynchronously to clk -> all outputs reset immediately: state 00, rst_state 1, increase 0, lap_hold 0. A button held across the reset yields no pulse until it has been released and pressed again.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: button synchronise/debounce/one-pulse, INIT/PAUSE/RUN FSM,
// tick divider producing the count-enable for the lowest counter digit, lap freeze flag.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10_000_000,
  parameter int DEB_DIV  = 100_000,
  parameter int DEB_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_reset,
  input  logic       btn_lap,
  output logic       increase,
  output logic       rst_state,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int FW = $clog2(DEB_LEN + 3);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_DIV - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEB_LEN + 2);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_PAUSE = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  // Button vector order: bit 0 start, bit 1 reset, bit 2 lap.
  logic [2:0]         raw, sync1, sync2, level, level_prev, armed, press;
  logic [DEB_LEN-1:0] shreg [3];
  logic [DW-1:0]      deb_cnt;
  logic [FW-1:0]      fill;
  logic               strobe, warm;
  logic               p_start, p_reset, p_lap;

  assign raw     = {btn_lap, btn_reset, btn_start};
  assign strobe  = (deb_cnt == DEB_LAST);
  assign warm    = (fill == FILL_FULL);
  assign p_start = press[0];
  assign p_reset = press[1];
  assign p_lap   = press[2];

  // A button is armed only once it has been seen released with real samples
  // (after the synchroniser and shift register have flushed), so a button held
  // through reset cannot fire until it is released and pressed again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      deb_cnt    <= '0;
      fill       <= '0;
      level      <= '0;
      level_prev <= '0;
      armed      <= '0;
      press      <= '0;
      for (int i = 0; i < 3; i++) shreg[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      deb_cnt <= strobe ? '0 : deb_cnt + DW'(1);
      if (strobe && !warm) fill <= fill + FW'(1);
      for (int i = 0; i < 3; i++) begin
        if (strobe) shreg[i] <= {shreg[i][DEB_LEN-2:0], sync2[i]};
        if (&shreg[i]) level[i] <= 1'b1;
        else if (~|shreg[i]) level[i] <= 1'b0;
        if (warm && ~|shreg[i]) armed[i] <= 1'b1;
      end
      level_prev <= level;
      press      <= armed & level & ~level_prev;
    end
  end

  state_t cur, nxt;
  logic [TW-1:0] tick;

  always_comb begin
    nxt = cur;
    case (cur)
      ST_INIT:  if (p_start) nxt = ST_RUN;
      ST_PAUSE: if (p_reset) nxt = ST_INIT; else if (p_start) nxt = ST_RUN;
      ST_RUN:   if (p_reset) nxt = ST_INIT; else if (p_start) nxt = ST_PAUSE;
      default:  nxt = ST_INIT;
    endcase
  end

  // Tick and increase decisions use the current state, so a terminal count on
  // the RUN->PAUSE cycle still emits its pulse and the counter parks at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= ST_INIT;
      tick      <= '0;
      increase  <= 1'b0;
      rst_state <= 1'b1;
      lap_hold  <= 1'b0;
    end else begin
      cur       <= nxt;
      rst_state <= (nxt == ST_INIT);
      increase  <= (cur == ST_RUN) && (tick == TICK_LAST);
      case (cur)
        ST_RUN:   tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
        ST_PAUSE: tick <= tick;
        default:  tick <= '0;
      endcase
      if (nxt == ST_INIT) lap_hold <= 1'b0;
      else if (cur == ST_RUN && p_lap) lap_hold <= ~lap_hold;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: table of button presses, hand-written corner sequences,
// and randomized presses/glitches against a press-level model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam logic [1:0] S_INIT = 2'b00, S_PAUSE = 2'b01, S_RUN = 2'b10;

  logic clk = 1'b0, rst_n = 1'b1;
  logic btn_start = 1'b0, btn_reset = 1'b0, btn_lap = 1'b0;
  logic increase, rst_state, lap_hold;
  logic [1:0] state;

  int vec_cnt = 0, err_cnt = 0;
  int run_cnt = 0, inc_seen = 0;
  logic [1:0] m_state = S_INIT;
  logic       m_lap   = 1'b0;

  typedef struct {
    logic [2:0] btn;
    logic [1:0] st;
    logic       rs;
    logic       lap;
  } vec_t;
  vec_t tbl [15];

  stopwatch_ctrl #(.TICK_DIV(4), .DEB_DIV(2), .DEB_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_reset(btn_reset),
    .btn_lap(btn_lap), .increase(increase), .rst_state(rst_state),
    .lap_hold(lap_hold), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulses since the last INIT must equal one per completed TICK_DIV cycles of
  // RUN time, seen one cycle after the RUN cycle that completed the period.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_cnt  = 0;
      inc_seen = 0;
    end else begin
      if (increase) inc_seen++;
      if (state == S_INIT) begin
        run_cnt  = 0;
        inc_seen = 0;
      end else begin
        if (state == S_RUN) run_cnt++;
        check("inc_count", inc_seen, (run_cnt - ((state == S_RUN) ? 1 : 0)) / TICK_DIV);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [2:0] b, input int hold, input int gap);
    {btn_lap, btn_reset, btn_start} = b;
    tick(hold);
    {btn_lap, btn_reset, btn_start} = 3'b000;
    tick(gap);
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n;
    n = -1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (state == s) begin
        n = k;
        break;
      end
    end
    vec_cnt++;
    if (n < 0) begin
      err_cnt++;
      $display("FAIL %s: state %0d never reached %0d", name, state, s);
    end
  endtask

  task automatic first_inc(input string name, input int exp);
    int k;
    k = 0;
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      if (increase) begin
        k = j;
        break;
      end
    end
    check(name, k, exp);
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check({name, "_state"}, state, S_INIT);
    check({name, "_rst_state"}, rst_state, 1);
    check({name, "_increase"}, increase, 0);
    check({name, "_lap_hold"}, lap_hold, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(1);
  endtask

  task automatic model_apply(input logic [2:0] b);
    if (m_state == S_RUN && b[2]) m_lap = ~m_lap;
    if (b[1] && m_state != S_INIT) m_state = S_INIT;
    else if (b[0]) m_state = (m_state == S_RUN) ? S_PAUSE : S_RUN;
    if (m_state == S_INIT) m_lap = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", vec_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int entry, bad, cnt, r, m;
    logic prev_rs;
    logic inc_hist [0:40];
    logic [2:0] b;

    tbl[0]  = '{3'b010, S_INIT,  1'b1, 1'b0};
    tbl[1]  = '{3'b100, S_INIT,  1'b1, 1'b0};
    tbl[2]  = '{3'b001, S_RUN,   1'b0, 1'b0};
    tbl[3]  = '{3'b100, S_RUN,   1'b0, 1'b1};
    tbl[4]  = '{3'b001, S_PAUSE, 1'b0, 1'b1};
    tbl[5]  = '{3'b100, S_PAUSE, 1'b0, 1'b1};
    tbl[6]  = '{3'b001, S_RUN,   1'b0, 1'b1};
    tbl[7]  = '{3'b100, S_RUN,   1'b0, 1'b0};
    tbl[8]  = '{3'b011, S_INIT,  1'b1, 1'b0};
    tbl[9]  = '{3'b001, S_RUN,   1'b0, 1'b0};
    tbl[10] = '{3'b101, S_PAUSE, 1'b0, 1'b1};
    tbl[11] = '{3'b110, S_INIT,  1'b1, 1'b0};
    tbl[12] = '{3'b001, S_RUN,   1'b0, 1'b0};
    tbl[13] = '{3'b100, S_RUN,   1'b0, 1'b1};
    tbl[14] = '{3'b010, S_INIT,  1'b1, 1'b0};

    // Power-on reset
    #3 rst_n = 1'b0;
    #1;
    check("por_state", state, S_INIT);
    check("por_rst_state", rst_state, 1);
    check("por_increase", increase, 0);
    check("por_lap_hold", lap_hold, 0);
    tick(3);
    rst_n = 1'b1;
    tick(20);

    // Short glitches never reach DEB_LEN samples
    bad = 0;
    for (int g = 0; g < 5; g++) begin
      btn_start = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        if (state != S_INIT || increase) bad++;
      end
      btn_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        if (state != S_INIT || increase) bad++;
      end
    end
    tick(12);
    check("glitch_bad_samples", bad, 0);
    check("glitch_state", state, S_INIT);

    // Long hold of start: one transition to RUN, then a pulse every TICK_DIV
    btn_start = 1'b1;
    entry = -1;
    prev_rs = rst_state;
    for (int c = 1; c <= 32; c++) begin
      tick(1);
      inc_hist[c] = increase;
      if (entry < 0 && state == S_RUN) begin
        entry = c;
        check("entry_rst_state_low", rst_state, 0);
        check("entry_rst_state_prev", prev_rs, 1);
      end
      prev_rs = rst_state;
      if (c == 20) btn_start = 1'b0;
    end
    check("start_latency_ok", (entry > 0 && entry <= 14) ? 1 : 0, 1);
    if (entry > 0 && entry <= 14) begin
      for (int j = 1; j <= 12; j++)
        check("first_ticks", inc_hist[entry + j], ((j % TICK_DIV) == 0) ? 1 : 0);
    end
    tick(10);
    check("single_start_pulse", state, S_RUN);

    // Pause and resume at several phases; the counter keeps its phase in PAUSE
    for (int d = 0; d < 4; d++) begin
      tick(d);
      btn_start = 1'b1;
      wait_state(S_PAUSE, "pause_entry");
      btn_start = 1'b0;
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
        tick(1);
        if (increase) cnt++;
      end
      check("pause_silent", cnt, 0);
      r = run_cnt;
      m = ((r + TICK_DIV) / TICK_DIV) * TICK_DIV;
      btn_start = 1'b1;
      wait_state(S_RUN, "resume_entry");
      first_inc("resume_first_inc", m - r);
      btn_start = 1'b0;
      tick(14);
    end

    // Coincident start and reset pulses: reset wins, no tick afterwards
    {btn_reset, btn_start} = 2'b11;
    wait_state(S_INIT, "start_reset_init");
    tick(1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (increase || !rst_state || state != S_INIT) bad++;
      tick(1);
    end
    {btn_reset, btn_start} = 2'b00;
    check("start_reset_quiet", bad, 0);
    tick(10);
    btn_start = 1'b1;
    wait_state(S_RUN, "restart_entry");
    first_inc("restart_first_inc", TICK_DIV);
    btn_start = 1'b0;
    tick(14);

    // Lap freeze does not disturb counting
    press(3'b100, 14, 16);
    check("lap_on", lap_hold, 1);
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      tick(1);
      if (increase) cnt++;
    end
    check("lap_ticks", cnt, 4);
    press(3'b100, 14, 16);
    check("lap_off", lap_hold, 0);
    press(3'b100, 14, 16);
    check("lap_on_again", lap_hold, 1);
    press(3'b010, 14, 16);
    check("lap_reset_lap", lap_hold, 0);
    check("lap_reset_state", state, S_INIT);
    check("lap_reset_rst_state", rst_state, 1);

    // Async reset mid-RUN with start held across it
    press(3'b001, 14, 16);
    check("pre_reset_run", state, S_RUN);
    press(3'b100, 14, 16);
    check("pre_reset_lap", lap_hold, 1);
    btn_start = 1'b1;
    tick(3);
    async_reset("mid_run_reset");
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (state != S_INIT) bad++;
    end
    check("held_no_pulse", bad, 0);
    btn_start = 1'b0;
    tick(16);
    press(3'b001, 14, 16);
    check("repress_run", state, S_RUN);

    // Table of presses from a fresh reset
    async_reset("table_reset");
    tick(20);
    for (int i = 0; i < 15; i++) begin
      press(tbl[i].btn, 14, 16);
      check("tbl_state", state, tbl[i].st);
      check("tbl_rst_state", rst_state, tbl[i].rs);
      check("tbl_lap_hold", lap_hold, tbl[i].lap);
    end

    // Randomized presses and glitches against the press-level model
    m_state = S_INIT;
    m_lap   = 1'b0;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 11);
      if (r >= 10) begin
        b = 3'($urandom_range(1, 7));
        {btn_lap, btn_reset, btn_start} = b;
        tick($urandom_range(1, 3));
        {btn_lap, btn_reset, btn_start} = 3'b000;
        tick(10);
      end else begin
        case (r)
          0, 1, 2, 3, 4: b = 3'b001;
          5, 6:          b = 3'b100;
          7:             b = 3'b010;
          8:             b = 3'b011;
          default:       b = 3'($urandom_range(1, 7));
        endcase
        model_apply(b);
        press(b, $urandom_range(12, 20), $urandom_range(14, 20));
      end
      check("rnd_state", state, m_state);
      check("rnd_rst_state", rst_state, (m_state == S_INIT) ? 1 : 0);
      check("rnd_lap_hold", lap_hold, m_lap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
